tt_bin_clock_input: RTL



---
 rtl/tt_bin_clock_input.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tt_bin_clock_input.sv
// Button conditioner for tt_bin_clock.
// Each raw push-button is synchronized, debounced and edge-detected. The result is a clean,
// registered, single-cycle command pulse. Hour and minute buttons auto-repeat while held.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   btn_raw_i    raw buttons: [4] hour inc, [3] hour dec, [2] min inc, [1] min dec, [0] meridiem
//   hour_id      hour command pulse:   [1] increment, [0] decrement
//   minute_id    minute command pulse: [1] increment, [0] decrement
//   meridiem_id  meridiem toggle pulse
//   held_o       high while any debounced button is pressed
module tt_bin_clock_input #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_DELAY    = 64,
   parameter int unsigned REPEAT_PERIOD   = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] btn_raw_i,
   output logic [1:0] hour_id,
   output logic [1:0] minute_id,
   output logic       meridiem_id,
   output logic       held_o
);

   localparam int unsigned NumBtn = 5;
   localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RepW   = $clog2(RepMax + 1);
   localparam int unsigned PrimeW = $clog2(SYNC_STAGES + 1);

   localparam logic [DbW-1:0]    DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RepW-1:0]   DelayLoad  = RepW'(REPEAT_DELAY - 1);
   localparam logic [RepW-1:0]   PeriodLoad = RepW'(REPEAT_PERIOD - 1);
   localparam logic [PrimeW-1:0] PrimeLast  = PrimeW'(SYNC_STAGES);

   typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

   // Synchronizer chain; stage 0 samples the pins directly.
   logic [NumBtn-1:0] sync_q [SYNC_STAGES];
   logic [NumBtn-1:0] synced;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= btn_raw_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // The synchronizer holds reset zeros for SYNC_STAGES cycles; until then a "released"
   // reading is not trustworthy and must not arm the buttons.
   logic [PrimeW-1:0] prime_q, prime_d;
   logic              primed;

   assign primed  = (prime_q == PrimeLast);
   assign prime_d = primed ? prime_q : prime_q + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) prime_q <= '0;
      else       prime_q <= prime_d;
   end

   logic [NumBtn-1:0] level_vec;
   logic [NumBtn-1:0] pulse_req;

   for (genvar i = 0; i < NumBtn; i++) begin : g_btn
      // Meridiem (bit 0) never auto-repeats.
      localparam bit RepEn = (i != 0);

      logic [DbW-1:0]  db_cnt_q, db_cnt_d;
      logic            level_q, level_d;
      logic            prev_q;
      logic            arm_q, arm_d;
      logic            rise;
      logic            pulse;
      state_e          state_q, state_d;
      logic [RepW-1:0] rep_q, rep_d;

      // Debounce: count consecutive cycles of disagreement, then adopt the synced value.
      always_comb begin
         db_cnt_d = '0;
         level_d  = level_q;
         if (synced[i] != level_q) begin
            if (db_cnt_q == DbLast) level_d  = synced[i];
            else                    db_cnt_d = db_cnt_q + 1'b1;
         end
      end

      // A button held through reset must be seen released before its press counts.
      assign arm_d = arm_q | (primed & ~synced[i] & ~level_q);
      assign rise  = level_q & ~prev_q & arm_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            prev_q   <= 1'b0;
            arm_q    <= 1'b0;
            state_q  <= StIdle;
            rep_q    <= '0;
         end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            prev_q   <= level_q;
            arm_q    <= arm_d;
            state_q  <= state_d;
            rep_q    <= rep_d;
         end
      end

      always_comb begin
         state_d = state_q;
         rep_d   = rep_q;
         unique case (state_q)
            StIdle: begin
               if (rise && RepEn) begin
                  state_d = StHold;
                  rep_d   = DelayLoad;
               end
            end
            StHold: begin
               if (!level_q) begin
                  state_d = StIdle;
               end else if (rep_q == '0) begin
                  state_d = StRepeat;
                  rep_d   = PeriodLoad;
               end else begin
                  rep_d = rep_q - 1'b1;
               end
            end
            StRepeat: begin
               if (!level_q)            state_d = StIdle;
               else if (rep_q == '0)    rep_d   = PeriodLoad;
               else                     rep_d   = rep_q - 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end

      // Release (level low) wins over a terminal count in the same cycle.
      always_comb begin
         pulse = 1'b0;
         unique case (state_q)
            StIdle:           pulse = rise;
            StHold, StRepeat: pulse = level_q && (rep_q == '0);
            default:          pulse = 1'b0;
         endcase
      end

      assign level_vec[i] = level_q;
      assign pulse_req[i] = pulse;
   end

   // Opposing requests on the same field cancel for that cycle.
   logic [1:0] hour_d, minute_d;

   assign hour_d   = {pulse_req[4] & ~pulse_req[3], pulse_req[3] & ~pulse_req[4]};
   assign minute_d = {pulse_req[2] & ~pulse_req[1], pulse_req[1] & ~pulse_req[2]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hour_id     <= '0;
         minute_id   <= '0;
         meridiem_id <= 1'b0;
         held_o      <= 1'b0;
      end else begin
         hour_id     <= hour_d;
         minute_id   <= minute_d;
         meridiem_id <= pulse_req[0];
         held_o      <= |level_vec;
      end
   end

endmodule
